// File: rtl/usb_in_ep_buffer.sv
// Single-packet IN endpoint buffer between a client and the USB FS protocol engine.
// Optional: define USB_IN_EP_AUTO_COMMIT_EN to commit automatically when the buffer fills.
module usb_in_ep_buffer #(
  parameter int MAX_PKT = 32,
  parameter int PTR_W   = $clog2(MAX_PKT) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_ep_req,
  output logic             in_ep_grant,
  output logic             in_ep_data_free,
  input  logic             in_ep_data_put,
  input  logic [7:0]       in_ep_data,
  input  logic             in_ep_data_done,
  input  logic             in_ep_stall,
  output logic             in_ep_acked,
  input  logic             pe_in_token,
  input  logic             pe_setup,
  output logic             pe_resp_valid,
  output logic [1:0]       pe_resp,
  output logic             pe_data_pid,
  output logic             pe_tx_avail,
  input  logic             pe_tx_get,
  output logic [7:0]       pe_tx_data,
  output logic             pe_tx_last,
  input  logic             pe_ack,
  input  logic             pe_timeout
);

  localparam int                IDX_W      = PTR_W - 1;
  localparam logic [PTR_W-1:0]  MAX_LEN    = PTR_W'(MAX_PKT);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
  localparam logic [1:0]        RESP_NAK   = 2'd0;
  localparam logic [1:0]        RESP_DATA  = 2'd1;
  localparam logic [1:0]        RESP_STALL = 2'd2;

  typedef enum logic [1:0] {FILL, READY, SEND, WAIT_ACK} state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] len_reg, len_next;
  logic             toggle_reg, toggle_next;
  logic             grant_reg, grant_next;
  logic             resp_valid_reg, resp_valid_next;
  logic [1:0]       resp_reg, resp_next;
  logic             acked_reg, acked_next;
  logic [7:0]       mem [MAX_PKT];

  logic put_ok;
  logic tx_avail;
  logic tx_last;

  assign in_ep_data_free = (state_reg == FILL) && (wr_ptr_reg < MAX_LEN);
  assign put_ok          = grant_reg && in_ep_data_free && in_ep_data_put;
  assign tx_avail        = (state_reg == SEND) && (rd_ptr_reg < len_reg);
  assign tx_last         = tx_avail && (rd_ptr_reg == len_reg - PTR_ONE);

  assign in_ep_grant   = grant_reg;
  assign in_ep_acked   = acked_reg;
  assign pe_resp_valid = resp_valid_reg;
  assign pe_resp       = resp_reg;
  assign pe_data_pid   = toggle_reg;
  assign pe_tx_avail   = tx_avail;
  assign pe_tx_last    = tx_last;
  // Outputs stay at zero whenever no byte is being offered to the engine.
  assign pe_tx_data    = tx_avail ? mem[rd_ptr_reg[IDX_W-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (put_ok) begin
      mem[wr_ptr_reg[IDX_W-1:0]] <= in_ep_data;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    len_next        = len_reg;
    toggle_next     = toggle_reg;
    resp_valid_next = 1'b0;
    resp_next       = RESP_NAK;
    acked_next      = 1'b0;
    grant_next      = in_ep_req && (state_reg == FILL);

    // A token racing an ACK in WAIT_ACK is dropped; the ACK completes the packet.
    if (pe_in_token && !pe_setup && (state_reg != SEND) &&
        !((state_reg == WAIT_ACK) && pe_ack)) begin
      resp_valid_next = 1'b1;
      if (in_ep_stall)             resp_next = RESP_STALL;
      else if (state_reg == FILL)  resp_next = RESP_NAK;
      else                         resp_next = RESP_DATA;
    end

    case (state_reg)
      FILL: begin
        if (put_ok) wr_ptr_next = wr_ptr_reg + PTR_ONE;
        if (in_ep_data_done && grant_reg) begin
          len_next   = wr_ptr_reg + PTR_W'(put_ok);
          state_next = READY;
        end
`ifdef USB_IN_EP_AUTO_COMMIT_EN
        if (put_ok && (wr_ptr_reg == MAX_LEN - PTR_ONE)) begin
          len_next   = MAX_LEN;
          state_next = READY;
        end
`endif
      end
      READY: begin
        if (pe_in_token && !in_ep_stall) begin
          rd_ptr_next = '0;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (pe_tx_get && tx_avail) begin
          rd_ptr_next = rd_ptr_reg + PTR_ONE;
          if (tx_last) state_next = WAIT_ACK;
        end else if (!tx_avail) begin
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (pe_ack) begin
          toggle_next = ~toggle_reg;
          wr_ptr_next = '0;
          acked_next  = 1'b1;
          state_next  = FILL;
        end else if (pe_in_token && !in_ep_stall) begin
          rd_ptr_next = '0;
          state_next  = SEND;
        end else if (pe_timeout) begin
          state_next = READY;
        end
      end
      default: state_next = FILL;
    endcase

    if (pe_setup) begin
      toggle_next = 1'b1;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      len_next    = '0;
      acked_next  = 1'b0;
      state_next  = FILL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= FILL;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      len_reg        <= '0;
      toggle_reg     <= 1'b0;
      grant_reg      <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_reg       <= RESP_NAK;
      acked_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      len_reg        <= len_next;
      toggle_reg     <= toggle_next;
      grant_reg      <= grant_next;
      resp_valid_reg <= resp_valid_next;
      resp_reg       <= resp_next;
      acked_reg      <= acked_next;
    end
  end

endmodule
